// File: rtl/training_case_feeder_pkg.sv
// Shared DNN sizing and fetch-FSM state encoding, also used by the weight-memory loader.
package training_case_feeder_pkg;

  localparam int WIDTH_IN = 8;
  localparam int N_IN     = 1024;
  localparam int N_OUT    = 16;
  localparam int Z0       = 512;
  localparam int FO0      = 8;

  localparam int CPC     = N_IN * FO0 / Z0 + 2;
  localparam int S       = CPC - 2;
  localparam int W       = WIDTH_IN * Z0 / FO0;
  localparam int IDX_W   = $clog2(CPC);
  localparam int SLICE_W = $clog2(S);
  localparam int WORD_W  = $clog2(S + 1);
  localparam int Y_W     = N_OUT / S;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    FULL = 2'd3
  } fetch_state_e;

  // $clog2 that never yields a zero-width vector
  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/training_case_feeder_if.sv
// Single-outstanding word-read bus between the case feeder and the training-case memory.
interface training_case_feeder_if #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 512
);
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;

  modport master (output rd_en, output rd_addr, input rd_data, input rd_valid);
  modport slave  (input rd_en, input rd_addr, output rd_data, output rd_valid);
endinterface

// File: rtl/training_case_feeder_case_buffer_2x.sv
// Two slice banks plus label registers; the shadow side is written while the active side is read.
module training_case_feeder_case_buffer_2x
  import training_case_feeder_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en,
  input  logic               wr_label,
  input  logic [SLICE_W-1:0] wr_idx,
  input  logic [W-1:0]       wr_data,
  input  logic               swap,
  input  logic [SLICE_W-1:0] rd_idx,
  output logic [W-1:0]       rd_slice,
  output logic [N_OUT-1:0]   rd_label
);

  logic             active_q;
  logic [W-1:0]     bank_q  [2][S];
  logic [N_OUT-1:0] label_q [2];

  always_ff @(posedge clk) begin
    if (reset) begin
      active_q <= 1'b0;
      for (int b = 0; b < 2; b++) begin
        label_q[b] <= '0;
        for (int s = 0; s < S; s++) begin
          bank_q[b][s] <= '0;
        end
      end
    end else begin
      if (swap) begin
        active_q <= ~active_q;
      end
      if (wr_en && wr_label) begin
        label_q[~active_q] <= wr_data[N_OUT-1:0];
      end else if (wr_en) begin
        bank_q[~active_q][wr_idx] <= wr_data;
      end
    end
  end

  assign rd_slice = bank_q[active_q][rd_idx];
  assign rd_label = label_q[active_q];

endmodule

// File: rtl/training_case_feeder.sv
// Prefetches one training case into a shadow buffer and streams the active case to the DNN,
// one slice per clock, aligned to the block-cycle counter.
//
// state | meaning
// IDLE  | unused holding state, falls through to REQ
// REQ   | rd_en high for one clock at rd_addr
// WAIT  | one read outstanding, waiting for rd_valid
// FULL  | shadow holds a complete case, waiting for cycle_clk to swap
module training_case_feeder
  import training_case_feeder_pkg::*;
#(
  parameter  int TRAINING_CASES = 10000,
  localparam int ADDR_W = clog2_min1(TRAINING_CASES * (S + 1)),
  localparam int CASE_W = clog2_min1(TRAINING_CASES)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cycle_clk,
  input  logic [IDX_W-1:0]      cycle_index,
  training_case_feeder_if.master mem,
  output logic [W-1:0]          a_in,
  output logic [Y_W-1:0]        y_in,
  output logic                  case_valid,
  output logic [CASE_W-1:0]     case_id,
  output logic [15:0]           epoch,
  output logic                  underrun
);

  fetch_state_e        state_q, state_d;
  logic [WORD_W-1:0]   word_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [CASE_W-1:0]   fetch_case_q;
  logic                last_word;
  logic                capture;
  logic                swap;
  logic [SLICE_W-1:0]  feed_idx;
  logic [W-1:0]        slice_rd;
  logic [N_OUT-1:0]    label_rd;

  assign last_word = (word_q == WORD_W'(S));
  assign capture   = (state_q == WAIT) && mem.rd_valid;
  assign swap      = cycle_clk && (state_q == FULL);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = REQ;
      REQ:     state_d = WAIT;
      WAIT:    if (mem.rd_valid) state_d = last_word ? FULL : REQ;
      FULL:    if (cycle_clk) state_d = REQ;
      default: state_d = REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= REQ;
      word_q       <= '0;
      addr_q       <= '0;
      fetch_case_q <= '0;
      case_valid   <= 1'b0;
      case_id      <= '0;
      epoch        <= '0;
      underrun     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        word_q <= last_word ? '0 : word_q + 1'b1;
        addr_q <= (addr_q == ADDR_W'(TRAINING_CASES * (S + 1) - 1)) ? '0 : addr_q + 1'b1;
      end
      if (cycle_clk && (state_q != FULL)) begin
        underrun <= 1'b1;
      end
      if (swap) begin
        case_valid   <= 1'b1;
        case_id      <= fetch_case_q;
        fetch_case_q <= (fetch_case_q == CASE_W'(TRAINING_CASES - 1)) ? '0 : fetch_case_q + 1'b1;
        // case index returning to 0 on a live feed closes an epoch
        if (case_valid && (fetch_case_q == '0) && (epoch != 16'hFFFF)) begin
          epoch <= epoch + 1'b1;
        end
      end
    end
  end

  // Reset is folded in so the memory sees no request while the block is held in reset.
  assign mem.rd_en   = (state_q == REQ) && !reset;
  assign mem.rd_addr = addr_q;

  training_case_feeder_case_buffer_2x u_buf (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (capture),
    .wr_label (last_word),
    .wr_idx   (word_q[SLICE_W-1:0]),
    .wr_data  (mem.rd_data),
    .swap     (swap),
    .rd_idx   (feed_idx),
    .rd_slice (slice_rd),
    .rd_label (label_rd)
  );

  // Two-clock DNN pipeline delay: index 0..1 replay the wrapped last slices.
  assign feed_idx = SLICE_W'(cycle_index) - SLICE_W'(2);
  assign a_in     = case_valid ? slice_rd : '0;
  assign y_in     = case_valid ? label_rd[feed_idx*Y_W +: Y_W] : '0;

endmodule

// File: tb/tb_training_case_feeder.sv
// Directed bench for training_case_feeder with a 4-case epoch and a latency-programmable memory.
module tb_training_case_feeder;

  localparam int TC     = 4;
  localparam int ADDR_W = 7;
  localparam int CASE_W = 2;

  logic              clk;
  logic              reset;
  logic              cycle_clk;
  logic [4:0]        cycle_index;
  logic [511:0]      a_in;
  logic [0:0]        y_in;
  logic              case_valid;
  logic [CASE_W-1:0] case_id;
  logic [15:0]       epoch;
  logic              underrun;

  training_case_feeder_if #(.ADDR_W(ADDR_W), .DATA_W(512)) mem_if ();

  training_case_feeder #(.TRAINING_CASES(TC)) dut (
    .clk         (clk),
    .reset       (reset),
    .cycle_clk   (cycle_clk),
    .cycle_index (cycle_index),
    .mem         (mem_if),
    .a_in        (a_in),
    .y_in        (y_in),
    .case_valid  (case_valid),
    .case_id     (case_id),
    .epoch       (epoch),
    .underrun    (underrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks   = 0;
  int failures = 0;
  int mem_lat  = 1;
  bit exp_valid;
  int exp_case;

  // case c slice j = {64{c[3:0],j[3:0]}}, label word = 1 << (c % 10)
  function automatic logic [511:0] exp_slice(input int c, input int j);
    logic [3:0] c4, j4;
    c4 = c[3:0];
    j4 = j[3:0];
    return {64{c4, j4}};
  endfunction

  function automatic logic [511:0] mem_word(input int addr);
    int c, j;
    logic [511:0] w;
    c = addr / 17;
    j = addr % 17;
    if (j < 16) begin
      w = exp_slice(c, j);
    end else begin
      w = '0;
      w[15:0] = 16'(1) << (c % 10);
    end
    return w;
  endfunction

  typedef struct {
    int addr;
    int rem;
  } req_t;
  req_t pend[$];

  // memory model: requests seen at negedge, answered mem_lat negedges later
  initial begin
    mem_if.rd_valid = 1'b0;
    mem_if.rd_data  = '0;
    forever begin
      @(negedge clk);
      mem_if.rd_valid = 1'b0;
      for (int i = 0; i < pend.size(); i++) pend[i].rem = pend[i].rem - 1;
      if (pend.size() > 0 && pend[0].rem <= 0) begin
        mem_if.rd_valid = 1'b1;
        mem_if.rd_data  = mem_word(pend[0].addr);
        void'(pend.pop_front());
      end
      if (mem_if.rd_en === 1'b1) pend.push_back('{int'(mem_if.rd_addr), mem_lat});
    end
  end

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int idx);
    @(posedge clk);
    #1;
    cycle_index = 5'(idx);
    cycle_clk   = (idx == 17);
    #1;
  endtask

  task automatic check_feed(input int idx);
    int k;
    logic [511:0] ea;
    logic ey;
    k  = (idx + 14) % 16;
    ea = exp_valid ? exp_slice(exp_case, k) : '0;
    ey = exp_valid ? (k == (exp_case % 10)) : 1'b0;
    chk($sformatf("a_in idx%0d case%0d", idx, exp_case), a_in, ea);
    chk($sformatf("y_in idx%0d case%0d", idx, exp_case), 512'(y_in), 512'(ey));
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, " rd_en"}, 512'(mem_if.rd_en), 0);
    chk({tag, " rd_addr"}, 512'(mem_if.rd_addr), 0);
    chk({tag, " case_valid"}, 512'(case_valid), 0);
    chk({tag, " case_id"}, 512'(case_id), 0);
    chk({tag, " epoch"}, 512'(epoch), 0);
    chk({tag, " underrun"}, 512'(underrun), 0);
    chk({tag, " a_in"}, a_in, 0);
    chk({tag, " y_in"}, 512'(y_in), 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) tick(0);
    check_reset_values("reset");
    pend.delete();
    @(posedge clk);
    #1;
    reset       = 1'b0;
    cycle_index = 5'd0;
    cycle_clk   = 1'b0;
    #1;
    exp_valid = 1'b0;
    exp_case  = 0;
  endtask

  typedef struct {
    bit rst;
    int lat;
    int gap;
    bit ev;
    int eid;
    int eep;
    bit eur;
    int eaddr;
  } row_t;
  row_t rows [22];

  task automatic run_row(input int r);
    mem_lat = rows[r].lat;
    if (rows[r].rst) do_reset();
    for (int g = 0; g < rows[r].gap; g++) begin
      tick(0);
      check_feed(0);
    end
    for (int i = 1; i < 18; i++) begin
      tick(i);
      check_feed(i);
    end
    tick(0);
    chk($sformatf("row%0d case_valid", r), 512'(case_valid), 512'(rows[r].ev));
    chk($sformatf("row%0d case_id", r), 512'(case_id), 512'(rows[r].eid));
    chk($sformatf("row%0d epoch", r), 512'(epoch), 512'(rows[r].eep));
    chk($sformatf("row%0d underrun", r), 512'(underrun), 512'(rows[r].eur));
    if (rows[r].eaddr >= 0) chk($sformatf("row%0d rd_addr", r), 512'(mem_if.rd_addr), 512'(rows[r].eaddr));
    exp_valid = rows[r].ev;
    exp_case  = rows[r].eid;
    check_feed(0);
  endtask

  initial begin
    reset       = 1'b1;
    cycle_clk   = 1'b0;
    cycle_index = 5'd0;
    exp_valid   = 1'b0;
    exp_case    = 0;

    //          rst lat gap ev id ep ur addr
    rows[0]  = '{1, 1, 24, 1, 0, 0, 0, 17};
    rows[1]  = '{0, 1, 24, 1, 1, 0, 0, 34};
    rows[2]  = '{0, 1, 24, 1, 2, 0, 0, 51};
    rows[3]  = '{0, 1, 24, 1, 3, 0, 0, 0};
    rows[4]  = '{0, 1, 24, 1, 0, 1, 0, 17};
    rows[5]  = '{0, 1, 24, 1, 1, 1, 0, 34};
    rows[6]  = '{0, 1, 24, 1, 2, 1, 0, 51};
    rows[7]  = '{0, 1, 24, 1, 3, 1, 0, 0};
    rows[8]  = '{0, 1, 24, 1, 0, 2, 0, 17};
    rows[9]  = '{0, 1, 24, 1, 1, 2, 0, 34};
    rows[10] = '{0, 1, 24, 1, 0, 0, 0, 17};
    rows[11] = '{0, 1, 24, 1, 1, 0, 0, 34};
    rows[12] = '{1, 3, 0,  0, 0, 0, 1, -1};
    rows[13] = '{0, 3, 0,  0, 0, 0, 1, -1};
    rows[14] = '{0, 3, 0,  0, 0, 0, 1, -1};
    rows[15] = '{0, 3, 0,  1, 0, 0, 1, 17};
    rows[16] = '{0, 3, 0,  1, 0, 0, 1, -1};
    rows[17] = '{0, 3, 0,  1, 0, 0, 1, -1};
    rows[18] = '{0, 3, 0,  1, 0, 0, 1, -1};
    rows[19] = '{0, 3, 0,  1, 1, 0, 1, 34};
    rows[20] = '{1, 1, 16, 0, 0, 0, 1, 17};
    rows[21] = '{0, 1, 0,  1, 0, 0, 1, 17};

    for (int r = 0; r < 10; r++) run_row(r);

    // reset while word 1 of case 2 is outstanding; its response lands in the first REQ clock
    mem_lat = 4;
    repeat (6) tick(0);
    chk("midfetch rd_addr", 512'(mem_if.rd_addr), 35);
    tick(0);
    reset = 1'b1;
    tick(0);
    check_reset_values("midreset");
    tick(0);
    reset = 1'b0;
    #1;
    chk("postreset rd_en", 512'(mem_if.rd_en), 1);
    chk("postreset rd_addr", 512'(mem_if.rd_addr), 0);
    tick(0);
    chk("stale ignored rd_addr", 512'(mem_if.rd_addr), 0);
    chk("stale ignored rd_en", 512'(mem_if.rd_en), 0);
    mem_lat   = 1;
    exp_valid = 1'b0;
    exp_case  = 0;

    for (int r = 10; r < 22; r++) run_row(r);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
